divider: RTL and testbench

DIVIDER -- requirements
Module: divider

---
 rtl/divider_pkg.sv | 24 ++
 rtl/divider_if.sv | 21 ++
 rtl/divider_div_step.sv | 19 +
 rtl/divider.sv | 118 +++++++++++
 tb/tb_divider.sv | 143 ++++++++++++++
 5 files changed

// File: rtl/divider_pkg.sv
// divider_pkg: shared op and FSM state encodings for the RV32M-style divider.
package divider_pkg;
    typedef enum logic [1:0] {
        OP_DIV  = 2'd0,
        OP_DIVU = 2'd1,
        OP_REM  = 2'd2,
        OP_REMU = 2'd3
    } div_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

    // op[0]=0 selects the signed variants, op[1]=1 selects remainder
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic op_is_rem(input logic [1:0] op);
        return op[1];
    endfunction
endpackage

// File: rtl/divider_if.sv
// divider_if: request/response handshake bundle between a requester and the divider.
interface divider_if #(parameter int WIDTH = 32);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;

    modport master (
        output in_valid, op, operand_a, operand_b, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, op, operand_a, operand_b, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/divider_div_step.sv
// div_step: one restoring shift-subtract step on unsigned magnitudes.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_qbit
);
    logic [WIDTH:0] w_part;
    logic [WIDTH:0] w_diff;

    assign w_part = {i_rem, i_bit};
    assign w_diff = w_part - {1'b0, i_divisor};
    // the top bit of the widened difference is the borrow of the trial subtract
    assign o_qbit = ~w_diff[WIDTH];
    assign o_rem  = o_qbit ? w_diff[WIDTH-1:0] : w_part[WIDTH-1:0];
endmodule

// File: rtl/divider.sv
// divider: multi-cycle restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Define DIVIDER_EARLY_OUT_EN to finish divide-by-zero and signed-overflow one cycle after acceptance.
module divider
    import divider_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic     clock,
    input  logic     reset,
    divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    div_state_t       r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_result;
    logic             r_rem_op;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_dz;
    logic             r_ovf;

    logic             w_accept;
    logic             w_signed;
    logic             w_a_neg;
    logic             w_b_neg;
    logic             w_dz;
    logic             w_ovf;
    logic             w_early;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH-1:0] w_step_rem;
    logic             w_step_bit;
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_r;
    logic [WIDTH-1:0] w_final;

    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.out_valid = (r_state == ST_DONE);
    assign bus.result    = r_result;

    assign w_accept = bus.in_valid && (r_state == ST_IDLE);
    assign w_signed = op_is_signed(bus.op);
    assign w_a_neg  = w_signed & bus.operand_a[WIDTH-1];
    assign w_b_neg  = w_signed & bus.operand_b[WIDTH-1];
    assign w_a_mag  = w_a_neg ? -bus.operand_a : bus.operand_a;
    assign w_b_mag  = w_b_neg ? -bus.operand_b : bus.operand_b;
    assign w_dz     = (bus.operand_b == '0);
    assign w_ovf    = w_signed && (bus.operand_a == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.operand_b == '1);

`ifdef DIVIDER_EARLY_OUT_EN
    assign w_early = w_dz | w_ovf;
`else
    assign w_early = 1'b0;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem     (r_rem),
        .i_bit     (r_quo[WIDTH-1]),
        .i_divisor (r_dvs),
        .o_rem     (w_step_rem),
        .o_qbit    (w_step_bit)
    );

    // special cases override the magnitude datapath so early-out needs no iterations
    assign w_q     = r_neg_q ? -r_quo : r_quo;
    assign w_r     = r_neg_r ? -r_rem : r_rem;
    assign w_final = r_dz  ? (r_rem_op ? r_a : '1) :
                     r_ovf ? (r_rem_op ? '0 : r_a) :
                     r_rem_op ? w_r : w_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_a      <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvs    <= '0;
            r_result <= '0;
            r_rem_op <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            if (w_accept) begin
                r_state  <= ST_BUSY;
                r_cnt    <= w_early ? '0 : CW'(WIDTH);
                r_a      <= bus.operand_a;
                r_rem    <= '0;
                r_quo    <= w_a_mag;
                r_dvs    <= w_b_mag;
                r_rem_op <= op_is_rem(bus.op);
                r_neg_q  <= w_a_neg ^ w_b_neg;
                r_neg_r  <= w_a_neg;
                r_dz     <= w_dz;
                r_ovf    <= w_ovf;
            end
        end else if (r_state == ST_BUSY) begin
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - CW'(1);
                r_rem <= w_step_rem;
                r_quo <= {r_quo[WIDTH-2:0], w_step_bit};
            end else begin
                r_state  <= ST_DONE;
                r_result <= w_final;
            end
        end else if (bus.out_ready) begin
            r_state  <= ST_IDLE;
            r_result <= '0;
        end
    end
endmodule

// File: tb/tb_divider.sv
// tb_divider: randomized and directed checks of divider against an arithmetic reference model.
module tb_divider;
    logic clock;
    logic reset;
    int   n_checks;
    int   n_fail;

    divider_if #(.WIDTH(32)) bus ();

    divider #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        sa = a;
        sb = b;
        if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : a;
        if (!op[0]) return op[1] ? 32'(sa % sb) : 32'(sa / sb);
        return op[1] ? a % b : a / b;
    endfunction

    function automatic int exp_latency(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef DIVIDER_EARLY_OUT_EN
        if (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
`endif
        return 33;
    endfunction

    task automatic run(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int hold, input bit chk_lat);
        int          lat;
        logic [31:0] exp;
        exp = model(op, a, b);
        bus.in_valid  = 1'b1;
        bus.op        = op;
        bus.operand_a = a;
        bus.operand_b = b;
        check({tag, ".in_ready"}, 64'(bus.in_ready), 64'd1);
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            if (lat == 5) check({tag, ".busy_result"}, 64'(bus.result), 64'd0);
            @(posedge clock);
            #1;
            lat++;
        end
        if (chk_lat) check({tag, ".latency"}, 64'(lat), 64'(exp_latency(op, a, b)));
        check({tag, ".out_valid"}, 64'(bus.out_valid), 64'd1);
        check({tag, ".result"}, 64'(bus.result), 64'(exp));
        for (int i = 0; i < hold; i++) begin
            @(posedge clock);
            #1;
            check({tag, ".hold"}, {31'd0, bus.out_valid, bus.result}, {32'd1, exp});
            check({tag, ".hold_in_ready"}, 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        check({tag, ".handoff_in_ready"}, 64'(bus.in_ready), 64'd0);
        @(posedge clock);
        #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        check({tag, ".after"}, {31'd0, bus.out_valid, bus.result}, 64'd0);
        check({tag, ".idle_ready"}, 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        n_checks      = 0;
        n_fail        = 0;
        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.op        = 2'd0;
        bus.operand_a = '0;
        bus.operand_b = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("reset.state", {bus.in_ready, bus.out_valid, 30'd0, bus.result}, {1'b1, 63'd0});
        reset = 1'b1;
        @(posedge clock);
        #1;
        run("divu_100_7", 2'd1, 32'd100, 32'd7, 0, 1'b1);
        run("remu_100_7", 2'd3, 32'd100, 32'd7, 0, 1'b1);
        run("div_m7_2", 2'd0, -32'sd7, 32'd2, 0, 1'b1);
        run("rem_m7_2", 2'd2, -32'sd7, 32'd2, 0, 1'b1);
        run("divu_5_0", 2'd1, 32'd5, 32'd0, 0, 1'b1);
        run("rem_5_0", 2'd2, 32'd5, 32'd0, 0, 1'b1);
        run("div_ovf", 2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b1);
        run("rem_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b1);
        run("stall", 2'd0, 32'd1000, -32'sd3, 10, 1'b1);
        bus.in_valid  = 1'b1;
        bus.op        = 2'd1;
        bus.operand_a = 32'hFFFF_FFFF;
        bus.operand_b = 32'd3;
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
        repeat (16) @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("midreset", {bus.in_ready, bus.out_valid, 30'd0, bus.result}, {1'b1, 63'd0});
        @(posedge clock);
        #1;
        reset = 1'b1;
        check("postreset", {bus.in_ready, bus.out_valid, 30'd0, bus.result}, {1'b1, 63'd0});
        run("after_reset", 2'd3, 32'd12345, 32'd77, 0, 1'b1);
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 : (($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 300)) : $urandom);
            if (i % 3 == 0) a = -a;
            if (i == 7) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end
            run($sformatf("rand%0d", i), op, a, b, i % 4, 1'b1);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
